// File: rtl/syn_sram_arb_if.sv
// Requester and SRAM-driver bus bundle for the shared SRAM arbiter.
// slave  = arbiter view, master = system/driver view.
interface syn_sram_arb_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 18
);
    logic              vga_req;
    logic              vga_we;
    logic [ADDR_W-1:0] vga_addr;
    logic [DATA_W-1:0] vga_wdata;
    logic              vga_ack;
    logic              vga_rd_valid;
    logic [DATA_W-1:0] vga_rdata;

    logic              gpu_req;
    logic              gpu_we;
    logic [ADDR_W-1:0] gpu_addr;
    logic [DATA_W-1:0] gpu_wdata;
    logic              gpu_ack;
    logic              gpu_rd_valid;
    logic [DATA_W-1:0] gpu_rdata;

    logic              sram_rdy;
    logic              sram_req;
    logic              sram_we;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic              sram_rd_valid;
    logic [DATA_W-1:0] sram_rdata;
    logic              err_unf;

    modport slave (
        input  vga_req, vga_we, vga_addr, vga_wdata,
        output vga_ack, vga_rd_valid, vga_rdata,
        input  gpu_req, gpu_we, gpu_addr, gpu_wdata,
        output gpu_ack, gpu_rd_valid, gpu_rdata,
        input  sram_rdy, sram_rd_valid, sram_rdata,
        output sram_req, sram_we, sram_addr, sram_wdata, err_unf
    );

    modport master (
        output vga_req, vga_we, vga_addr, vga_wdata,
        input  vga_ack, vga_rd_valid, vga_rdata,
        output gpu_req, gpu_we, gpu_addr, gpu_wdata,
        input  gpu_ack, gpu_rd_valid, gpu_rdata,
        output sram_rdy, sram_rd_valid, sram_rdata,
        input  sram_req, sram_we, sram_addr, sram_wdata, err_unf
    );
endinterface

// File: rtl/syn_sram_arb.sv
// Shared SRAM arbiter: VGA has fixed priority, GPU gets a forced slot after
// STARVE_LIM denied cycles. Outstanding reads are tagged in a small FIFO so
// in-order read returns are steered back to the requester that issued them.
module syn_sram_arb #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 18,
    parameter int TAG_DEPTH  = 4,
    parameter int STARVE_LIM = 8
) (
    input  logic          clk_ir,
    input  logic          rst_sync_l,
    syn_sram_arb_if.slave bus
);
    localparam int PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int CNT_W = $clog2(TAG_DEPTH) + 1;
    localparam int STV_W = $clog2(STARVE_LIM + 1);

    localparam logic [0:0] ARB_VGA_PRI   = 1'b0;
    localparam logic [0:0] ARB_GPU_FORCE = 1'b1;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(TAG_DEPTH);
    localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_LIM);

    logic [0:0]           r_state, w_state_nxt;
    logic [STV_W-1:0]     r_starve, w_starve_nxt;

    logic [TAG_DEPTH-1:0] r_tag;
    logic [PTR_W-1:0]     r_wptr, r_rptr;
    logic [CNT_W-1:0]     r_cnt;

    logic                 r_sram_req, r_sram_we;
    logic [ADDR_W-1:0]    r_sram_addr;
    logic [DATA_W-1:0]    r_sram_wdata;
    logic                 r_vga_rv, r_gpu_rv;
    logic [DATA_W-1:0]    r_vga_rdata, r_gpu_rdata;
    logic                 r_err_unf;

    logic w_full, w_empty;
    logic w_vga_elig, w_gpu_elig;
    logic w_gnt_vga, w_gnt_gpu;
    logic w_push, w_pop, w_pop_tag;

    assign w_full  = (r_cnt == FULL_CNT);
    assign w_empty = (r_cnt == '0);

    // A full tag FIFO blocks reads even if a pop lands the same cycle.
    assign w_vga_elig = bus.vga_req & bus.sram_rdy & (bus.vga_we | ~w_full);
    assign w_gpu_elig = bus.gpu_req & bus.sram_rdy & (bus.gpu_we | ~w_full);

    // Grant selection: priority flips to GPU while in the forced state.
    always_comb begin
        w_gnt_vga = 1'b0;
        w_gnt_gpu = 1'b0;
        if (rst_sync_l) begin
            if (r_state == ARB_GPU_FORCE) begin
                if (w_gpu_elig)      w_gnt_gpu = 1'b1;
                else if (w_vga_elig) w_gnt_vga = 1'b1;
            end else begin
                if (w_vga_elig)      w_gnt_vga = 1'b1;
                else if (w_gpu_elig) w_gnt_gpu = 1'b1;
            end
        end
    end

    // Starvation tracking: enter the forced state on the edge the count hits the limit.
    always_comb begin
        w_state_nxt  = r_state;
        w_starve_nxt = r_starve;
        case (r_state)
            ARB_VGA_PRI: begin
                if (!bus.gpu_req || w_gnt_gpu)
                    w_starve_nxt = '0;
                else if (r_starve != STV_MAX)
                    w_starve_nxt = r_starve + STV_W'(1);
                if (w_starve_nxt == STV_MAX)
                    w_state_nxt = ARB_GPU_FORCE;
            end
            ARB_GPU_FORCE: begin
                if (w_gnt_gpu || !bus.gpu_req) begin
                    w_state_nxt  = ARB_VGA_PRI;
                    w_starve_nxt = '0;
                end
            end
            default: begin
                w_state_nxt  = ARB_VGA_PRI;
                w_starve_nxt = '0;
            end
        endcase
    end

    assign w_push    = (w_gnt_vga & ~bus.vga_we) | (w_gnt_gpu & ~bus.gpu_we);
    assign w_pop     = bus.sram_rd_valid & ~w_empty;
    assign w_pop_tag = r_tag[r_rptr];

    // Arbiter state and starvation counter.
    always_ff @(posedge clk_ir or negedge rst_sync_l) begin
        if (!rst_sync_l) begin
            r_state  <= ARB_VGA_PRI;
            r_starve <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_starve <= w_starve_nxt;
        end
    end

    // Registered command to the SRAM driver; payload holds when idle.
    always_ff @(posedge clk_ir or negedge rst_sync_l) begin
        if (!rst_sync_l) begin
            r_sram_req   <= 1'b0;
            r_sram_we    <= 1'b0;
            r_sram_addr  <= '0;
            r_sram_wdata <= '0;
        end else begin
            r_sram_req <= w_gnt_vga | w_gnt_gpu;
            if (w_gnt_vga) begin
                r_sram_we    <= bus.vga_we;
                r_sram_addr  <= bus.vga_addr;
                r_sram_wdata <= bus.vga_wdata;
            end else if (w_gnt_gpu) begin
                r_sram_we    <= bus.gpu_we;
                r_sram_addr  <= bus.gpu_addr;
                r_sram_wdata <= bus.gpu_wdata;
            end
        end
    end

    // Owner-tag FIFO (0=VGA, 1=GPU); pointers wrap naturally at TAG_DEPTH.
    always_ff @(posedge clk_ir or negedge rst_sync_l) begin
        if (!rst_sync_l) begin
            r_tag  <= '0;
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) begin
                r_tag[r_wptr] <= w_gnt_gpu;
                r_wptr        <= r_wptr + PTR_W'(1);
            end
            if (w_pop)
                r_rptr <= r_rptr + PTR_W'(1);
            if (w_push && !w_pop)
                r_cnt <= r_cnt + CNT_W'(1);
            else if (!w_push && w_pop)
                r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    // Read return steering and sticky underflow flag.
    always_ff @(posedge clk_ir or negedge rst_sync_l) begin
        if (!rst_sync_l) begin
            r_vga_rv    <= 1'b0;
            r_gpu_rv    <= 1'b0;
            r_vga_rdata <= '0;
            r_gpu_rdata <= '0;
            r_err_unf   <= 1'b0;
        end else begin
            r_vga_rv <= w_pop & ~w_pop_tag;
            r_gpu_rv <= w_pop &  w_pop_tag;
            if (w_pop && !w_pop_tag) r_vga_rdata <= bus.sram_rdata;
            if (w_pop &&  w_pop_tag) r_gpu_rdata <= bus.sram_rdata;
            if (bus.sram_rd_valid && w_empty) r_err_unf <= 1'b1;
        end
    end

    assign bus.vga_ack      = w_gnt_vga;
    assign bus.gpu_ack      = w_gnt_gpu;
    assign bus.vga_rd_valid = r_vga_rv;
    assign bus.gpu_rd_valid = r_gpu_rv;
    assign bus.vga_rdata    = r_vga_rdata;
    assign bus.gpu_rdata    = r_gpu_rdata;
    assign bus.sram_req     = r_sram_req;
    assign bus.sram_we      = r_sram_we;
    assign bus.sram_addr    = r_sram_addr;
    assign bus.sram_wdata   = r_sram_wdata;
    assign bus.err_unf      = r_err_unf;
endmodule

// File: tb/tb_syn_sram_arb.sv
// Bench for syn_sram_arb: single-cycle vector table, directed corner-case
// sequences, and a randomized run, all shadowed by a queue-based reference model.
module tb_syn_sram_arb;
    localparam int DW    = 16;
    localparam int AW    = 18;
    localparam int DEPTH = 4;
    localparam int LIM   = 8;

    logic clk_ir = 1'b0;
    logic rst_sync_l = 1'b0;
    always #5 clk_ir = ~clk_ir;

    syn_sram_arb_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    syn_sram_arb #(.DATA_W(DW), .ADDR_W(AW), .TAG_DEPTH(DEPTH), .STARVE_LIM(LIM)) dut (
        .clk_ir     (clk_ir),
        .rst_sync_l (rst_sync_l),
        .bus        (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    bit echo  = 1'b0;

    // ---------------- reference model ----------------
    int          tagq[$];
    int          m_starve;
    bit          m_force;
    logic        m_sreq, m_swe, m_vrv, m_grv, m_err;
    logic [AW-1:0] m_saddr;
    logic [DW-1:0] m_swd, m_vrd, m_grd;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        tagq.delete();
        m_starve = 0; m_force = 0;
        m_sreq = 0; m_swe = 0; m_saddr = '0; m_swd = '0;
        m_vrv = 0; m_grv = 0; m_vrd = '0; m_grd = '0; m_err = 0;
    endtask

    task automatic m_grant(output bit gv, output bit gg);
        bit full, ve, ge;
        full = (tagq.size() >= DEPTH);
        ve = bus.vga_req && bus.sram_rdy && (bus.vga_we || !full);
        ge = bus.gpu_req && bus.sram_rdy && (bus.gpu_we || !full);
        gv = 0; gg = 0;
        if (m_force) begin
            if (ge) gg = 1; else if (ve) gv = 1;
        end else begin
            if (ve) gv = 1; else if (ge) gg = 1;
        end
    endtask

    task automatic model_step();
        bit gv, gg;
        int t;
        m_grant(gv, gg);
        chk("m_vga_ack", bus.vga_ack, gv);
        chk("m_gpu_ack", bus.gpu_ack, gg);
        chk("m_sram_req", bus.sram_req, m_sreq);
        chk("m_sram_we", bus.sram_we, m_swe);
        chk("m_sram_addr", bus.sram_addr, m_saddr);
        chk("m_sram_wdata", bus.sram_wdata, m_swd);
        chk("m_vga_rv", bus.vga_rd_valid, m_vrv);
        chk("m_gpu_rv", bus.gpu_rd_valid, m_grv);
        chk("m_vga_rdata", bus.vga_rdata, m_vrd);
        chk("m_gpu_rdata", bus.gpu_rdata, m_grd);
        chk("m_err_unf", bus.err_unf, m_err);
        // starvation bookkeeping
        if (m_force) begin
            if (gg || !bus.gpu_req) begin m_force = 0; m_starve = 0; end
        end else begin
            if (gg || !bus.gpu_req) m_starve = 0;
            else if (m_starve < LIM) m_starve++;
            if (m_starve == LIM) m_force = 1;
        end
        // read return, in order
        m_vrv = 0; m_grv = 0;
        if (bus.sram_rd_valid) begin
            if (tagq.size() == 0) m_err = 1;
            else begin
                t = tagq.pop_front();
                if (t == 0) begin m_vrv = 1; m_vrd = bus.sram_rdata; end
                else        begin m_grv = 1; m_grd = bus.sram_rdata; end
            end
        end
        // command issue
        if (gv || gg) begin
            m_sreq  = 1;
            m_swe   = gv ? bus.vga_we    : bus.gpu_we;
            m_saddr = gv ? bus.vga_addr  : bus.gpu_addr;
            m_swd   = gv ? bus.vga_wdata : bus.gpu_wdata;
            if (!m_swe) tagq.push_back(gg ? 1 : 0);
        end else begin
            m_sreq = 0;
        end
    endtask

    // one clock: model checks/advances at negedge, returns at posedge+1
    task automatic step();
        @(negedge clk_ir);
        if (rst_sync_l) model_step();
        else            model_reset();
        @(posedge clk_ir);
        #1;
        bus.sram_rd_valid = echo ? (bus.sram_req && !bus.sram_we) : 1'b0;
        bus.sram_rdata    = {4'hE, 12'(bus.sram_addr)};
    endtask

    task automatic set_idle();
        bus.vga_req = 0; bus.vga_we = 0; bus.vga_addr = '0; bus.vga_wdata = '0;
        bus.gpu_req = 0; bus.gpu_we = 0; bus.gpu_addr = '0; bus.gpu_wdata = '0;
        bus.sram_rdy = 1; bus.sram_rd_valid = 0; bus.sram_rdata = '0;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_vack"}, bus.vga_ack, 0);
        chk({nm, "_gack"}, bus.gpu_ack, 0);
        chk({nm, "_sreq"}, bus.sram_req, 0);
        chk({nm, "_swe"}, bus.sram_we, 0);
        chk({nm, "_saddr"}, bus.sram_addr, 0);
        chk({nm, "_swd"}, bus.sram_wdata, 0);
        chk({nm, "_vrv"}, bus.vga_rd_valid, 0);
        chk({nm, "_grv"}, bus.gpu_rd_valid, 0);
        chk({nm, "_vrd"}, bus.vga_rdata, 0);
        chk({nm, "_grd"}, bus.gpu_rdata, 0);
        chk({nm, "_err"}, bus.err_unf, 0);
    endtask

    task automatic do_reset();
        rst_sync_l = 0;
        set_idle();
        model_reset();
        #1;
        chk_all_zero("rst");
        step(); step();
        rst_sync_l = 1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic vreq, vwe, greq, gwe, rdy;
        logic e_vack, e_gack, e_sreq, e_swe;
        logic [AW-1:0] e_saddr;
    } vec_t;

    localparam logic [AW-1:0] VA = 18'h12345;
    localparam logic [AW-1:0] GA = 18'h2ABCD;

    vec_t tbl[8];

    localparam logic [DW-1:0] RDAT[4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};

    initial begin
        int due_last;
        int pend[$];
        logic [DW-1:0] rd;

        tbl[0] = '{0,0,0,0,1, 0,0,0,0, '0};
        tbl[1] = '{1,0,0,0,1, 1,0,1,0, VA};
        tbl[2] = '{0,0,1,0,1, 0,1,1,0, GA};
        tbl[3] = '{1,0,1,0,1, 1,0,1,0, VA};
        tbl[4] = '{1,1,1,1,0, 0,0,0,0, '0};
        tbl[5] = '{1,1,1,0,1, 1,0,1,1, VA};
        tbl[6] = '{0,0,1,1,1, 0,1,1,1, GA};
        tbl[7] = '{1,0,0,0,0, 0,0,0,0, '0};

        set_idle();
        model_reset();

        for (int i = 0; i < 8; i++) begin
            do_reset();
            bus.vga_req = tbl[i].vreq; bus.vga_we = tbl[i].vwe; bus.vga_addr = VA;
            bus.gpu_req = tbl[i].greq; bus.gpu_we = tbl[i].gwe; bus.gpu_addr = GA;
            bus.sram_rdy = tbl[i].rdy;
            #1;
            chk("tbl_vack", bus.vga_ack, tbl[i].e_vack);
            chk("tbl_gack", bus.gpu_ack, tbl[i].e_gack);
            step();
            set_idle();
            #1;
            chk("tbl_sreq", bus.sram_req, tbl[i].e_sreq);
            chk("tbl_swe", bus.sram_we, tbl[i].e_swe);
            chk("tbl_saddr", bus.sram_addr, tbl[i].e_saddr);
            step();
        end

        // back-to-back reads from both: VGA wins until it drops
        do_reset(); echo = 1;
        for (int k = 0; k < 6; k++) begin
            bus.vga_req = 1; bus.vga_we = 0; bus.vga_addr = 18'(32'h100 + k);
            bus.gpu_req = 1; bus.gpu_we = 0; bus.gpu_addr = 18'h200;
            #1;
            chk("s1_vack", bus.vga_ack, 1);
            chk("s1_gack", bus.gpu_ack, 0);
            if (k > 0) begin
                chk("s1_sreq", bus.sram_req, 1);
                chk("s1_saddr", bus.sram_addr, 32'h100 + k - 1);
            end
            step();
        end
        bus.vga_req = 0;
        #1;
        chk("s1_gack_after", bus.gpu_ack, 1);
        chk("s1_saddr5", bus.sram_addr, 32'h105);
        step();
        bus.gpu_req = 0;
        #1;
        chk("s1_sreq_gpu", bus.sram_req, 1);
        chk("s1_saddr_gpu", bus.sram_addr, 32'h200);
        repeat (3) step();

        // starvation: VGA writes nonstop, GPU forced at cycle 8
        do_reset(); echo = 1;
        for (int c = 0; c < 12; c++) begin
            bus.vga_req = 1; bus.vga_we = 1; bus.vga_addr = 18'(c);
            bus.gpu_req = 1; bus.gpu_we = 1; bus.gpu_addr = 18'h3F000;
            #1;
            chk("s2_vack", bus.vga_ack, (c != 8));
            chk("s2_gack", bus.gpu_ack, (c == 8));
            step();
        end

        // in-order read return routing, 3-cycle latency
        do_reset(); echo = 0;
        for (int c = 0; c < 9; c++) begin
            set_idle();
            bus.vga_req = (c == 0 || c == 3);
            bus.gpu_req = (c == 1 || c == 2);
            bus.vga_addr = 18'(c); bus.gpu_addr = 18'(c);
            if (c >= 3 && c <= 6) begin
                bus.sram_rd_valid = 1;
                bus.sram_rdata = RDAT[c-3];
            end
            #1;
            chk("s3_vack", bus.vga_ack, (c == 0 || c == 3));
            chk("s3_gack", bus.gpu_ack, (c == 1 || c == 2));
            chk("s3_vrv", bus.vga_rd_valid, (c == 4 || c == 7));
            chk("s3_grv", bus.gpu_rd_valid, (c == 5 || c == 6));
            if (c == 4) chk("s3_vrd0", bus.vga_rdata, 32'h1111);
            if (c == 5) chk("s3_grd0", bus.gpu_rdata, 32'h2222);
            if (c == 6) chk("s3_grd1", bus.gpu_rdata, 32'h3333);
            if (c >= 7) chk("s3_vrd1", bus.vga_rdata, 32'h4444);
            if (c == 8) chk("s3_grd_hold", bus.gpu_rdata, 32'h3333);
            step();
        end

        // tag FIFO full blocks reads but not writes
        do_reset(); echo = 0;
        for (int c = 0; c < 9; c++) begin
            set_idle();
            bus.gpu_req = (c <= 7);
            bus.gpu_we  = (c == 5);
            bus.gpu_addr = 18'(c);
            bus.sram_rd_valid = (c == 6);
            bus.sram_rdata = 16'h5A5A;
            #1;
            chk("s4_gack", bus.gpu_ack, (c <= 3 || c == 5 || c == 7));
            if (c == 7) chk("s4_grv", bus.gpu_rd_valid, 1);
            step();
        end

        // sram_rdy low stalls everything
        do_reset(); echo = 1;
        for (int c = 0; c < 6; c++) begin
            bus.vga_req = 1; bus.gpu_req = 1; bus.vga_addr = 18'h777;
            bus.sram_rdy = (c == 5);
            #1;
            chk("s5_vack", bus.vga_ack, (c == 5));
            chk("s5_gack", bus.gpu_ack, 0);
            chk("s5_sreq", bus.sram_req, 0);
            step();
        end
        set_idle();
        #1;
        chk("s5_sreq_go", bus.sram_req, 1);
        step();

        // underflow sticky, then async reset clears everything
        do_reset(); echo = 0;
        bus.sram_rd_valid = 1; bus.sram_rdata = 16'hDEAD;
        step();
        set_idle();
        #1;
        chk("s6_vrv", bus.vga_rd_valid, 0);
        chk("s6_grv", bus.gpu_rd_valid, 0);
        chk("s6_err", bus.err_unf, 1);
        bus.vga_req = 1; bus.vga_we = 1; bus.vga_addr = 18'h3ABC; bus.vga_wdata = 16'hBEEF;
        step();
        #1;
        chk("s6_err_hold", bus.err_unf, 1);
        chk("s6_sreq", bus.sram_req, 1);
        chk("s6_saddr", bus.sram_addr, 32'h3ABC);
        bus.gpu_req = 1;
        #2;
        rst_sync_l = 0;
        model_reset();
        #1;
        chk_all_zero("s6_async");
        step();
        rst_sync_l = 1;
        set_idle();

        // randomized traffic against the model, with one mid-run reset
        do_reset(); echo = 0;
        due_last = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int pv;
            pv = (cyc < 1000) ? 90 : 55;
            bus.vga_req   = ($urandom_range(0, 99) < pv);
            bus.vga_we    = $urandom_range(0, 2) == 0;
            bus.vga_addr  = 18'($urandom);
            bus.vga_wdata = 16'($urandom);
            bus.gpu_req   = ($urandom_range(0, 99) < 60);
            bus.gpu_we    = $urandom_range(0, 2) == 0;
            bus.gpu_addr  = 18'($urandom);
            bus.gpu_wdata = 16'($urandom);
            bus.sram_rdy  = ($urandom_range(0, 99) < 85);
            if (bus.sram_req && !bus.sram_we) begin
                int d;
                d = cyc + int'($urandom_range(1, 4));
                if (d <= due_last) d = due_last + 1;
                due_last = d;
                pend.push_back(d);
            end
            bus.sram_rd_valid = 0;
            if (pend.size() > 0 && pend[0] <= cyc) begin
                void'(pend.pop_front());
                rd = 16'($urandom);
                bus.sram_rd_valid = 1;
                bus.sram_rdata = rd;
            end else if (pend.size() == 0 && $urandom_range(0, 499) == 0) begin
                bus.sram_rd_valid = 1;
                bus.sram_rdata = 16'($urandom);
            end
            if (cyc == 1500) begin
                #2;
                rst_sync_l = 0;
                model_reset();
                #1;
                chk("rnd_rst_sreq", bus.sram_req, 0);
                chk("rnd_rst_err", bus.err_unf, 0);
            end
            step();
            if (cyc == 1500) rst_sync_l = 1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
